// File: rtl/instr_sequencer_pkg.sv
// rtl/instr_sequencer_pkg.sv - shared opcodes, states and instruction fields
// Purpose: opcode constants (ALU ops are shared with the ALU), FSM state
//          encoding, instruction field positions and flag bit positions.
// Ports:   none (package).
package instr_sequencer_pkg;

    localparam int INSTR_W = 16;
    localparam int OPC_HI  = 15;
    localparam int OPC_LO  = 10;
    localparam int RSV_HI  = 9;
    localparam int RSV_LO  = 8;
    localparam int IMM_HI  = 7;
    localparam int IMM_LO  = 0;

    // Bit positions inside the latched flag word {s,p,ov,cy,z}
    localparam int FLG_Z  = 0;
    localparam int FLG_CY = 1;
    localparam int FLG_OV = 2;
    localparam int FLG_P  = 3;
    localparam int FLG_S  = 4;

    typedef enum logic [5:0] {
        OP_NOP  = 6'h00,
        OP_NOT  = 6'h01,
        OP_XOR  = 6'h02,
        OP_OR   = 6'h03,
        OP_AND  = 6'h04,
        OP_SUB  = 6'h05,
        OP_ADD  = 6'h06,
        OP_RR   = 6'h07,
        OP_RL   = 6'h08,
        OP_DEC  = 6'h09,
        OP_INC  = 6'h0A,
        OP_LDI  = 6'h10,
        OP_JMP  = 6'h20,
        OP_JZ   = 6'h21,
        OP_JC   = 6'h22,
        OP_HALT = 6'h3F
    } opcode_t;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_WAIT  = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    function automatic logic is_alu_op(input logic [5:0] op);
        return (op >= 6'(OP_NOT)) && (op <= 6'(OP_INC));
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// rtl/instr_sequencer_if.sv - program memory and ALU bus bundle
// Purpose: groups the program memory read port and the ALU operand/result
//          signals between the sequencer (master) and memory/ALU (slave).
// Signals: pm_addr, pm_rd_en, pm_rdata; alu_instr_code, alu_in_data,
//          alu_reg_file, alu_result, alu_flag_{z,cy,ov,p,s}.
interface instr_sequencer_if #(
    parameter int PC_W = 8
);
    logic [PC_W-1:0] pm_addr;
    logic            pm_rd_en;
    logic [15:0]     pm_rdata;
    logic [5:0]      alu_instr_code;
    logic [7:0]      alu_in_data;
    logic [7:0]      alu_reg_file;
    logic [7:0]      alu_result;
    logic            alu_flag_z;
    logic            alu_flag_cy;
    logic            alu_flag_ov;
    logic            alu_flag_p;
    logic            alu_flag_s;

    modport master (
        output pm_addr, pm_rd_en, alu_instr_code, alu_in_data, alu_reg_file,
        input  pm_rdata, alu_result, alu_flag_z, alu_flag_cy, alu_flag_ov,
               alu_flag_p, alu_flag_s
    );

    modport slave (
        input  pm_addr, pm_rd_en, alu_instr_code, alu_in_data, alu_reg_file,
        output pm_rdata, alu_result, alu_flag_z, alu_flag_cy, alu_flag_ov,
               alu_flag_p, alu_flag_s
    );
endinterface

// File: rtl/instr_sequencer_flag_reg.sv
// rtl/instr_sequencer_flag_reg.sv - flag latch with per-bit load enables
// Purpose: holds {s,p,ov,cy,z}; each bit loads only when its enable is set.
// Ports:   clk, rst_n (async active-low), i_load[W] enables, i_d[W] data,
//          o_q[W] latched flags.
module instr_sequencer_flag_reg #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_load,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else begin
            r_q <= (r_q & ~i_load) | (i_d & i_load);
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetch/decode/execute controller for the 8-bit ALU
// Purpose: fetches 16-bit instructions, drives the ALU, writes back the
//          accumulator and flags, resolves jumps. One instruction in flight.
// Ports:   clk, rst_n (async active-low), en (advance enable),
//          bus (master: program memory + ALU), acc, flags {s,p,ov,cy,z},
//          halted.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    instr_sequencer_if.master   bus,
    output logic [7:0]          acc,
    output logic [4:0]          flags,
    output logic                halted
);
    state_t              r_state;
    state_t              w_next_state;
    logic [PC_W-1:0]     r_pc;
    logic [INSTR_W-1:0]  r_ir;
    logic [7:0]          r_acc;
    logic [5:0]          w_opcode;
    logic [7:0]          w_imm;
    logic                w_is_alu;
    logic [PC_W-1:0]     w_target;
    logic [4:0]          w_flag_load;
    logic [4:0]          w_flag_d;
    logic [1:0]          w_unused_rsvd;

    assign w_opcode      = r_ir[OPC_HI:OPC_LO];
    assign w_imm         = r_ir[IMM_HI:IMM_LO];
    assign w_unused_rsvd = r_ir[RSV_HI:RSV_LO];
    assign w_is_alu      = is_alu_op(w_opcode);
    assign w_target      = PC_W'(w_imm);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
        end else if (en) begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc  <= RESET_PC;
            r_ir  <= '0;
            r_acc <= '0;
        end else if (en) begin
            case (r_state)
                ST_WAIT: begin
                    r_ir <= bus.pm_rdata;
                    r_pc <= r_pc + 1'b1;
                end
                ST_EXEC: begin
                    case (w_opcode)
                        OP_LDI: r_acc <= w_imm;
                        OP_JMP: r_pc  <= w_target;
                        // Conditional jumps test the latched flags only
                        OP_JZ:  if (flags[FLG_Z])  r_pc <= w_target;
                        OP_JC:  if (flags[FLG_CY]) r_pc <= w_target;
                        default: ;
                    endcase
                end
                ST_WB: r_acc <= bus.alu_result;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next_state       = r_state;
        bus.pm_rd_en       = 1'b0;
        bus.alu_instr_code = 6'(OP_NOP);
        case (r_state)
            ST_FETCH: begin
                // Gated by rst_n so the strobe reads 0 while reset is held
                bus.pm_rd_en = en & rst_n;
                w_next_state = ST_WAIT;
            end
            ST_WAIT: w_next_state = ST_EXEC;
            ST_EXEC: begin
                if (w_is_alu) begin
                    bus.alu_instr_code = w_opcode;
                    w_next_state       = ST_WB;
                end else if (w_opcode == 6'(OP_HALT)) begin
                    w_next_state = ST_HALT;
                end else begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_WB: begin
                bus.alu_instr_code = w_opcode;
                w_next_state       = ST_FETCH;
            end
            ST_HALT: w_next_state = ST_HALT;
            default: w_next_state = ST_FETCH;
        endcase
    end

    // cy follows the ALU only on ADD; the other flags load on every ALU op
    assign w_flag_load = (en && (r_state == ST_WB))
                       ? {1'b1, 1'b1, 1'b1, (w_opcode == 6'(OP_ADD)), 1'b1}
                       : 5'b0;
    assign w_flag_d    = {bus.alu_flag_s, bus.alu_flag_p, bus.alu_flag_ov,
                          bus.alu_flag_cy, bus.alu_flag_z};

    instr_sequencer_flag_reg #(.W(5)) u_flag_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_flag_load),
        .i_d    (w_flag_d),
        .o_q    (flags)
    );

    assign bus.pm_addr      = r_pc;
    assign bus.alu_in_data  = r_acc;
    assign bus.alu_reg_file = w_imm;
    assign acc              = r_acc;
    assign halted           = (r_state == ST_HALT);
endmodule
